load_issue_scheduler: RTL and testbench

- Controls the load buffer datapath: holds up to DEPTH pending loads and issues them one at a time to a single-outstanding data memory port.
- Extends the returned word per load width.
- Arbitrates completed loads onto the common data bus (CDB) as {rob tag, data}.
- Sits between the load/store reservation stage and the data memory, with a CDB request/grant toward the CDB arbiter.

---
 rtl/load_issue_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_load_issue_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_issue_scheduler.sv
// load_issue_scheduler
//   Holds up to DEPTH pending loads. Issues them one at a time, in round-robin
//   order, to a data memory port that allows a single outstanding request.
//   Extends each returned word according to the load width. Offers completed
//   loads to the CDB as {rob tag, data}.
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   flush               squash all entries on the next edge
//   in_valid/in_ready   new load handshake (in_ready = !is_full)
//   in_addr/in_width/in_rob  load byte address, funct3 width, ROB tag (0 = none)
//   is_full             every entry is occupied
//   mem_req/mem_addr    word-aligned read request, held until mem_rvalid
//   mem_rvalid/mem_rdata read response
//   cdb_req/cdb_grant   CDB request / grant
//   cdb_data            {tag, data} of the lowest-index DONE entry, zero when idle
module load_issue_scheduler #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_addr,
    input  logic [2:0]            in_width,
    input  logic [TAG_W-1:0]      in_rob,
    output logic                  is_full,
    output logic                  mem_req,
    output logic [XLEN-1:0]       mem_addr,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  cdb_req,
    input  logic                  cdb_grant,
    output logic [TAG_W+XLEN-1:0] cdb_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_FREE, S_PEND, S_ISSD, S_DONE} ent_state_t;

    ent_state_t       r_st    [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];
    logic [XLEN-1:0]  r_addr  [DEPTH];
    logic [2:0]       r_width [DEPTH];
    logic [XLEN-1:0]  r_data  [DEPTH];

    logic             r_busy;      // a memory request is outstanding
    logic             r_drop;      // swallow the response of a flushed request
    logic [IDX_W-1:0] r_iss_idx;   // entry owning the outstanding request
    logic [IDX_W-1:0] r_rr_ptr;
    logic [XLEN-1:0]  r_mem_addr;

    logic             w_full;
    logic             w_free_found, w_done_found, w_pend_found;
    logic [IDX_W-1:0] w_free_idx, w_done_idx, w_pend_idx, w_scan;
    logic             w_rsp, w_accept, w_issue, w_grant;
    logic [XLEN-1:0]  w_ext;

    // Byte lane from addr[1:0], half lane from addr[1]; unknown widths pass the word.
    function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] word,
                                                 input logic [1:0]      lane,
                                                 input logic [2:0]      width);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (width)
            3'b000:  f_extend = {{(XLEN-8){b[7]}}, b};
            3'b001:  f_extend = {{(XLEN-16){h[15]}}, h};
            3'b100:  f_extend = {{(XLEN-8){1'b0}}, b};
            3'b101:  f_extend = {{(XLEN-16){1'b0}}, h};
            default: f_extend = word;
        endcase
    endfunction

    // Lowest-index FREE / DONE entries and the full flag, all from registered state.
    always_comb begin
        w_full       = 1'b1;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_done_found = 1'b0;
        w_done_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_st[i] == S_FREE) begin
                w_full = 1'b0;
                if (!w_free_found) begin
                    w_free_found = 1'b1;
                    w_free_idx   = IDX_W'(i);
                end
            end
            if (r_st[i] == S_DONE && !w_done_found) begin
                w_done_found = 1'b1;
                w_done_idx   = IDX_W'(i);
            end
        end
    end

    // Circular scan for the first PENDING entry starting at rr_ptr; DEPTH is a
    // power of two so the index addition wraps naturally.
    always_comb begin
        w_pend_found = 1'b0;
        w_pend_idx   = '0;
        w_scan       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan = r_rr_ptr + IDX_W'(k);
            if (!w_pend_found && r_st[w_scan] == S_PEND) begin
                w_pend_found = 1'b1;
                w_pend_idx   = w_scan;
            end
        end
    end

    assign w_rsp    = mem_rvalid & r_busy;
    assign w_accept = in_valid & ~w_full & (in_rob != '0) & ~flush;
    // Issue may follow a completing response in the same cycle (back-to-back).
    assign w_issue  = w_pend_found & (~r_busy | w_rsp) & ~r_drop & ~flush;
    assign w_grant  = cdb_grant & w_done_found;
    assign w_ext    = f_extend(mem_rdata, r_addr[r_iss_idx][1:0], r_width[r_iss_idx]);

    // Each enabled transition touches a different entry, since it starts from
    // a different state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_st[i]    <= S_FREE;
                r_tag[i]   <= '0;
                r_addr[i]  <= '0;
                r_width[i] <= '0;
                r_data[i]  <= '0;
            end
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
            r_iss_idx  <= '0;
            r_rr_ptr   <= '0;
            r_mem_addr <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_st[i]  <= S_FREE;
                r_tag[i] <= '0;
            end
            r_busy <= 1'b0;
            // A response still owed by memory must not land in a reused entry.
            r_drop <= (r_busy | r_drop) & ~mem_rvalid;
        end else begin
            if (w_rsp) begin
                r_st[r_iss_idx]   <= S_DONE;
                r_data[r_iss_idx] <= w_ext;
                r_busy            <= 1'b0;
            end
            if (r_drop && mem_rvalid) begin
                r_drop <= 1'b0;
            end
            if (w_issue) begin
                r_st[w_pend_idx] <= S_ISSD;
                r_busy           <= 1'b1;
                r_iss_idx        <= w_pend_idx;
                r_mem_addr       <= {r_addr[w_pend_idx][XLEN-1:2], 2'b00};
                r_rr_ptr         <= w_pend_idx + IDX_W'(1);
            end
            if (w_grant) begin
                r_st[w_done_idx]  <= S_FREE;
                r_tag[w_done_idx] <= '0;
            end
            if (w_accept) begin
                r_st[w_free_idx]    <= S_PEND;
                r_tag[w_free_idx]   <= in_rob;
                r_addr[w_free_idx]  <= in_addr;
                r_width[w_free_idx] <= in_width;
            end
        end
    end

    assign is_full  = w_full;
    assign in_ready = ~w_full;
    assign mem_req  = r_busy;
    assign mem_addr = r_mem_addr;
    assign cdb_req  = w_done_found;
    assign cdb_data = w_done_found ? {r_tag[w_done_idx], r_data[w_done_idx]} : '0;

endmodule

// File: tb/tb_load_issue_scheduler.sv
module tb_load_issue_scheduler;

    localparam int TAG_W = 6;
    localparam int XLEN  = 32;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [XLEN-1:0]       in_addr = '0;
    logic [2:0]            in_width = '0;
    logic [TAG_W-1:0]      in_rob = '0;
    logic                  is_full;
    logic                  mem_req;
    logic [XLEN-1:0]       mem_addr;
    logic                  mem_rvalid = 1'b0;
    logic [XLEN-1:0]       mem_rdata = '0;
    logic                  cdb_req;
    logic                  cdb_grant = 1'b0;
    logic [TAG_W+XLEN-1:0] cdb_data;

    load_issue_scheduler #(.DEPTH(4), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_width(in_width), .in_rob(in_rob), .is_full(is_full),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
        .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [XLEN-1:0] addr;
        logic [2:0]      width;
        logic [XLEN-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [TAG_W-1:0] rob, input logic [XLEN-1:0] addr,
                        input logic [2:0] w);
        in_valid = 1'b1;
        in_rob   = rob;
        in_addr  = addr;
        in_width = w;
    endtask

    // Wait (bounded) for a request, answer it, check the CDB, then grant it.
    task automatic serve(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
        int n;
        n = 0;
        while (!mem_req && n < 8) begin
            step();
            n++;
        end
        chk("serve_mem_req", 64'(mem_req), 64'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step();
        mem_rvalid = 1'b0;
        chk("serve_cdb_req", 64'(cdb_req), 64'd1);
        chk("serve_cdb_data", 64'(cdb_data), 64'({tag, data}));
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Word 0x80FF7F01: bytes 01,7F,FF,80; halves 7F01, 80FF.
        vecs[0] = '{32'h2001, 3'b000, 32'h0000007F};
        vecs[1] = '{32'h2002, 3'b000, 32'hFFFFFFFF};
        vecs[2] = '{32'h2003, 3'b100, 32'h00000080};
        vecs[3] = '{32'h2002, 3'b001, 32'hFFFF80FF};
        vecs[4] = '{32'h2000, 3'b101, 32'h00007F01};
        vecs[5] = '{32'h2003, 3'b001, 32'hFFFF80FF};
        vecs[6] = '{32'h2001, 3'b101, 32'h00007F01};
        vecs[7] = '{32'h2000, 3'b000, 32'h00000001};
        vecs[8] = '{32'h2002, 3'b011, 32'h80FF7F01};
        vecs[9] = '{32'h2001, 3'b110, 32'h80FF7F01};

        // Reset state
        step();
        step();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_cdb_req", 64'(cdb_req), 64'd0);
        chk("rst_cdb_data", 64'(cdb_data), 64'd0);
        chk("rst_is_full", 64'(is_full), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset_n = 1'b1;
        step();

        // Single LW
        load(6'd5, 32'h1004, 3'b010);
        step();
        in_valid = 1'b0;
        chk("lw_req_not_yet", 64'(mem_req), 64'd0);
        step();
        chk("lw_mem_req", 64'(mem_req), 64'd1);
        chk("lw_mem_addr", 64'(mem_addr), 64'h1004);
        step();
        chk("lw_req_held", 64'(mem_req), 64'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        chk("lw_cdb_idle", 64'(cdb_req), 64'd0);
        step();
        mem_rvalid = 1'b0;
        chk("lw_cdb_req", 64'(cdb_req), 64'd1);
        chk("lw_cdb_data", 64'(cdb_data), 64'({6'd5, 32'hDEADBEEF}));
        chk("lw_req_drop", 64'(mem_req), 64'd0);
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
        chk("lw_freed_cdb", 64'(cdb_req), 64'd0);
        chk("lw_freed_data", 64'(cdb_data), 64'd0);

        // Extension table
        for (int i = 0; i < 10; i++) begin
            load(TAG_W'(i + 1), vecs[i].addr, vecs[i].width);
            step();
            in_valid = 1'b0;
            step();
            chk("ext_mem_req", 64'(mem_req), 64'd1);
            chk("ext_mem_addr", 64'(mem_addr), 64'h2000);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h80FF7F01;
            step();
            mem_rvalid = 1'b0;
            chk($sformatf("ext_data_%0d", i), 64'(cdb_data), 64'({TAG_W'(i + 1), vecs[i].exp}));
            cdb_grant = 1'b1;
            step();
            cdb_grant = 1'b0;
        end

        // Full
        for (int i = 1; i <= 4; i++) begin
            load(TAG_W'(i), 32'h100 * i, 3'b010);
            step();
        end
        in_valid = 1'b0;
        chk("full_is_full", 64'(is_full), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        load(6'd5, 32'h500, 3'b010);
        step();
        step();
        in_valid = 1'b0;
        chk("full_still_full", 64'(is_full), 64'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA1;
        step();
        mem_rvalid = 1'b0;
        chk("full_cdb_data", 64'(cdb_data), 64'({6'd1, 32'hA1}));
        chk("full_b2b_req", 64'(mem_req), 64'd1);
        chk("full_b2b_addr", 64'(mem_addr), 64'h200);
        cdb_grant = 1'b1;
        load(6'd6, 32'h600, 3'b010);
        step();
        cdb_grant = 1'b0;
        chk("full_freed", 64'(is_full), 64'd0);
        chk("full_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("full_refilled", 64'(is_full), 64'd1);
        serve(6'd2, 32'hB2);
        serve(6'd3, 32'hB3);
        serve(6'd4, 32'hB4);
        chk("full_slot0_addr", 64'(mem_addr), 64'h600);
        serve(6'd6, 32'hB6);
        chk("full_drained_req", 64'(mem_req), 64'd0);
        chk("full_drained_cdb", 64'(cdb_req), 64'd0);

        // Round-robin: restart from rr_ptr = 0
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) begin
            load(TAG_W'(i), 32'h100 * i, 3'b010);
            step();
        end
        in_valid = 1'b0;
        chk("rr_addr0", 64'(mem_addr), 64'h100);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11;
        cdb_grant  = 1'b1;
        step();
        chk("rr_req1", 64'(mem_req), 64'd1);
        chk("rr_addr1", 64'(mem_addr), 64'h200);
        step();
        chk("rr_req2", 64'(mem_req), 64'd1);
        chk("rr_addr2", 64'(mem_addr), 64'h300);
        chk("rr_slot0_free", 64'(in_ready), 64'd1);
        load(6'd8, 32'h500, 3'b010);
        step();
        in_valid = 1'b0;
        chk("rr_req3", 64'(mem_req), 64'd1);
        chk("rr_addr3", 64'(mem_addr), 64'h400);
        step();
        chk("rr_req4", 64'(mem_req), 64'd1);
        chk("rr_addr_refill", 64'(mem_addr), 64'h500);
        cdb_grant = 1'b0;
        mem_rdata = 32'h55;
        step();
        mem_rvalid = 1'b0;
        chk("rr_cdb_refill", 64'(cdb_data), 64'({6'd8, 32'h55}));
        cdb_grant = 1'b1;
        step();
        step();
        cdb_grant = 1'b0;
        chk("rr_empty_cdb", 64'(cdb_req), 64'd0);
        chk("rr_empty_req", 64'(mem_req), 64'd0);

        // Flush with outstanding request
        load(6'd3, 32'h40, 3'b010);
        step();
        in_valid = 1'b0;
        step();
        chk("fl_req_before", 64'(mem_req), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_req_cleared", 64'(mem_req), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        load(6'd9, 32'h80, 3'b010);
        step();
        in_valid = 1'b0;
        step();
        chk("fl_no_issue_a", 64'(mem_req), 64'd0);
        step();
        chk("fl_no_issue_b", 64'(mem_req), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111;
        step();
        mem_rvalid = 1'b0;
        chk("fl_dropped_cdb", 64'(cdb_req), 64'd0);
        chk("fl_dropped_req", 64'(mem_req), 64'd0);
        step();
        chk("fl_issue_req", 64'(mem_req), 64'd1);
        chk("fl_issue_addr", 64'(mem_addr), 64'h80);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h22223333;
        step();
        mem_rvalid = 1'b0;
        chk("fl_cdb_data", 64'(cdb_data), 64'({6'd9, 32'h22223333}));
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;

        // in_rob == 0 ignored
        load(6'd0, 32'h90, 3'b010);
        step();
        in_valid = 1'b0;
        step();
        chk("rob0_no_req", 64'(mem_req), 64'd0);

        // flush and in_valid together: flush wins
        load(6'd10, 32'hA0, 3'b010);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("flin_no_req", 64'(mem_req), 64'd0);
        chk("flin_no_cdb", 64'(cdb_req), 64'd0);

        // Reset mid-operation: one DONE entry and one outstanding request
        load(6'd11, 32'h3000, 3'b010);
        step();
        in_valid = 1'b0;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77;
        load(6'd13, 32'h3010, 3'b010);
        step();
        mem_rvalid = 1'b0;
        in_valid   = 1'b0;
        step();
        chk("mrst_pre_req", 64'(mem_req), 64'd1);
        chk("mrst_pre_cdb", 64'(cdb_req), 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mrst_mem_req", 64'(mem_req), 64'd0);
        chk("mrst_mem_addr", 64'(mem_addr), 64'd0);
        chk("mrst_cdb_req", 64'(cdb_req), 64'd0);
        chk("mrst_cdb_data", 64'(cdb_data), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        step();
        reset_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h99;
        step();
        mem_rvalid = 1'b0;
        step();
        chk("mrst_stray_cdb", 64'(cdb_req), 64'd0);
        chk("mrst_stray_req", 64'(mem_req), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
